domain_handshake_receiver: RTL

- Destination-domain end of the two-phase toggle REQ/ACK crossing.
- Samples a foreign-domain request toggle and its held data bus, then presents the word to a local consumer on a valid/ready interface.
- Returns an ACK toggle only after the consumer accepts, so the sender is back-pressured. The constant-handshake crossing has no such back-pressure.
- Used wherever a producer in another clock domain (e.g. input/paddle logic) must not lose words while the pixel-domain consumer stalls.

---
 rtl/domain_handshake_pkg.sv | 12 +
 rtl/bit_synchronizer.sv | 40 ++++
 rtl/domain_handshake_receiver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/domain_handshake_pkg.sv
// Shared types and limits for the two-phase REQ/ACK toggle crossing blocks.
// Both the receiver and future sender blocks import this package.
package domain_handshake_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_VALID = 1'b1
  } rx_state_t;

endpackage : domain_handshake_pkg

// File: rtl/bit_synchronizer.sv
// N-flop single-bit synchronizer with asynchronous active-low reset.
// Used for the REQ toggle here and for the ACK toggle in sender blocks.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    if (STAGES < 2) begin : g_stage_check
      $error("bit_synchronizer: STAGES must be at least 2");
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = d_i;
      end else begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/domain_handshake_receiver.sv
// Destination end of a two-phase REQ/ACK crossing with valid/ready back-pressure.
// Optional sticky overrun detection: define DOMAIN_HANDSHAKE_RX_OVERRUN_DETECT_EN.
module domain_handshake_receiver
  import domain_handshake_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ack,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_xfer_count,
  output logic                  o_overrun
);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_sync_check
      $error("domain_handshake_receiver: SYNC_STAGES below MIN_SYNC_STAGES");
    end
  endgenerate

  rx_state_t             state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sync_req;
  logic                  pending;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_req_sync (
    .clk_i  (i_clk),
    .rst_ni (rst),
    .d_i    (i_req),
    .q_o    (sync_req)
  );

  // A request is outstanding whenever the synchronized REQ level differs from our ACK level.
  assign pending = sync_req ^ ack_q;

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (pending) state_d = RX_VALID;
      RX_VALID: if (i_ready) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    ack_d   = ack_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      RX_IDLE: begin
        if (pending) begin
          data_d  = i_data;
          valid_d = 1'b1;
        end
      end
      RX_VALID: begin
        if (i_ready) begin
          ack_d   = ~ack_q;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DOMAIN_HANDSHAKE_RX_OVERRUN_DETECT_EN
  logic req_seen_q, req_seen_d;
  logic overrun_q, overrun_d;

  always_comb begin
    req_seen_d = req_seen_q;
    if (state_q == RX_IDLE && pending) begin
      req_seen_d = sync_req;
    end
  end

  // The sender toggled again before our ACK went back: flag it and never clear until reset.
  assign overrun_d = overrun_q | ((state_q == RX_VALID) && (sync_req != req_seen_q));

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      req_seen_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      req_seen_q <= req_seen_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_ack        = ack_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_xfer_count = cnt_q;

endmodule : domain_handshake_receiver
